uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, rdata bit positions and
// the default bit-period divider used by both the RX and TX UARTs.
package uart_pkg;

    // 50 MHz / 115200 baud
    localparam int UART_CLKDIV = 434;

    // rdata status bit positions
    localparam int RX_VALID_BIT = 8;
    localparam int RX_FERR_BIT  = 9;
    localparam int RX_OVR_BIT   = 10;
    localparam int RX_PERR_BIT  = 11;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, depth 2**AW, show-ahead read port (rdata is the head).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**AW
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with receive FIFO and sticky status flags.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity-error flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKDIV  = UART_CLKDIV,
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [15:0] HALF_LOAD = 16'(CLKDIV/2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKDIV - 1);

    rx_state_e   state, state_n;
    logic        rx_meta, rxs, rxs_q;
    logic [15:0] div_cnt, div_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shreg, shreg_n;
    logic        push, ferr_set, perr_set, ovr_set;
    logic        ferr, ovr, perr;
    logic        fifo_full, fifo_empty;
    logic [7:0]  head;
    logic        expired;

    assign expired = (div_cnt == '0);

    // Two-flop synchronizer plus one more stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_q   <= rxs;
        end
    end

    // FSM state and bit-timing datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RX_IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
        end
    end

    // Next-state: samples are taken mid-bit when the divider reaches zero
    always_comb begin
        state_n  = state;
        div_n    = (div_cnt != '0) ? div_cnt - 16'd1 : div_cnt;
        bit_n    = bit_idx;
        shreg_n  = shreg;
        push     = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rxs_q && !rxs) begin
                    state_n = RX_START;
                    div_n   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (expired) begin
                    if (rxs) begin
                        state_n = RX_IDLE;      // glitch, not a start bit
                    end else begin
                        state_n = RX_DATA;
                        div_n   = FULL_LOAD;
                        bit_n   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (expired) begin
                    shreg_n = {rxs, shreg[7:1]};
                    div_n   = FULL_LOAD;
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = RX_PARITY;
`else
                        state_n = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (expired) begin
                    perr_set = (rxs != ^shreg);
                    div_n    = FULL_LOAD;
                    state_n  = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (expired) begin
                    if (rxs) begin
                        push    = 1'b1;
                        state_n = RX_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Held-low line: one framing error, then wait for idle
                if (rxs) state_n = RX_IDLE;
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign ovr_set = push & fifo_full & ~re;

    // Sticky flags: cleared by a read, but a same-cycle set event wins
    always_ff @(posedge clk) begin
        if (reset) begin
            ferr <= 1'b0;
            ovr  <= 1'b0;
            perr <= 1'b0;
        end else begin
            ferr <= ferr_set | (ferr & ~re);
            ovr  <= ovr_set  | (ovr  & ~re);
            perr <= perr_set | (perr & ~re);
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (re),
        .wdata (shreg),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // CPU-visible status/data word
    always_comb begin
        rdata = '0;
        if (!fifo_empty) begin
            rdata[7:0]          = head;
            rdata[RX_VALID_BIT] = 1'b1;
        end
        rdata[RX_FERR_BIT] = ferr;
        rdata[RX_OVR_BIT]  = ovr;
        rdata[RX_PERR_BIT] = perr;
    end

    assign irq = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (CLKDIV=16, FIFO_AW=2) with an expected-word
// scoreboard; honours UART_RX_PARITY_EN for 8E1 framing.
module tb_uart_rx;

    localparam int CLKDIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // sync (2) + edge detect (1) + half bit to start sample (CLKDIV/2 - 1)
    // + (9+PAR) bit periods to stop sample + 1 cycle to push
    localparam int RISE_LAT = 3 + (CLKDIV/2 - 1) + (9 + PAR)*CLKDIV + 1;

    logic        clk = 1'b0;
    logic        reset, rx, re;
    logic [31:0] rdata;
    logic        irq;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          rise_cyc = -1;
    logic        irq_q = 1'b0;
    logic [31:0] exp_q [$];

    uart_rx #(.CLKDIV(CLKDIV), .FIFO_AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .re    (re),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle on which irq most recently rose
    always @(negedge clk) begin
        if (irq && !irq_q) rise_cyc = cyc;
        irq_q = irq;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (CLKDIV) @(posedge clk);
        #1;
    endtask

    // Drive one frame; rst_bit >= 0 pulses reset mid-way through that data bit
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic par_bad, input int rst_bit);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                rx = b[i];
                repeat (CLKDIV/2) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                @(negedge clk);
                check("rst_mid_rdata", rdata, 32'h0);
                check("rst_mid_irq", {31'b0, irq}, 32'h0);
                repeat (CLKDIV/2 - 1) @(posedge clk);
                #1;
            end else begin
                hold_bit(b[i]);
            end
        end
        if (PAR != 0) hold_bit((^b) ^ par_bad);
        hold_bit(stop);
        if (stop) rx = 1'b1;
    endtask

    // Wait for data, compare against scoreboard head, then pop it
    task automatic read_check(input string tag);
        logic [31:0] expv;
        for (int i = 0; i < 2000 && !irq; i++) @(negedge clk);
        @(negedge clk);
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check(tag, rdata, expv);
        @(posedge clk);
        #1 re = 1'b1;
        @(posedge clk);
        #1 re = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        re    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);

        // Single byte, push latency and read-clear
        exp_q.push_back(32'h1A5);
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        check("irq_rise_latency", rise_cyc - start_cyc, RISE_LAT);
        read_check("byte_a5");
        @(negedge clk);
        check("a5_after_read", rdata, 32'h0);
        check("a5_irq_low", {31'b0, irq}, 32'h0);

        // Short low glitch is rejected as a false start
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("glitch_rdata", rdata, 32'h0);
        check("glitch_irq", {31'b0, irq}, 32'h0);

        // Overrun: five bytes into a four-entry FIFO
        exp_q.push_back(32'h511);
        exp_q.push_back(32'h122);
        exp_q.push_back(32'h133);
        exp_q.push_back(32'h144);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        send_frame(8'h33, 1'b1, 1'b0, -1);
        send_frame(8'h44, 1'b1, 1'b0, -1);
        send_frame(8'h55, 1'b1, 1'b0, -1);
        for (int i = 0; i < 4; i++) read_check($sformatf("ovr_read%0d", i));
        @(negedge clk);
        check("ovr_empty", rdata, 32'h0);

        // Framing error followed by a held-low break, then a good byte
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("break_ferr", rdata, 32'h200);
        #1 rx = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("break_release", rdata, 32'h200);
        exp_q.push_back(32'h37E);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        read_check("after_break_7e");
        @(negedge clk);
        check("break_cleared", rdata, 32'h0);

        // Reset mid-frame with two bytes queued
        send_frame(8'h01, 1'b1, 1'b0, -1);
        send_frame(8'h02, 1'b1, 1'b0, -1);
        @(negedge clk);
        check("queued_two", rdata, 32'h101);
        send_frame(8'hF0, 1'b1, 1'b0, 4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("post_reset_frame", rdata, 32'h0);
        exp_q.push_back(32'h181);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        read_check("after_reset_81");
        @(negedge clk);
        check("final_empty", rdata, 32'h0);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(32'h907);
        send_frame(8'h07, 1'b1, 1'b1, -1);
        read_check("parity_bad");
        exp_q.push_back(32'h107);
        send_frame(8'h07, 1'b1, 1'b0, -1);
        read_check("parity_good");
`endif

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
